// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: accepts a, b, cin over a valid/ready handshake, resolves one
// bit per cycle LSB-first, then holds sum/cout in DONE until the consumer takes them.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (y & ci) | (x & ci), x ^ y ^ ci};
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;
    logic             r_busy;

    logic [1:0]       w_fa;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // Current bit of the addition and the end-of-operation flag.
    always_comb begin
        w_fa   = full_add(r_a_sh[0], r_b_sh[0], r_carry);
        w_s    = w_fa[0];
        w_c    = w_fa[1];
        w_last = (r_bit_cnt == CW'(WIDTH - 1));
    end

    // A single-bit sum register has nothing to shift down, so the new bit is the whole value.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_s;
        end else begin : g_sum_wn
            assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // Ready is gated by reset so nothing is offered as accepted while reset is held.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

    // Control FSM, datapath shift registers and output registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_bit_cnt   <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh    <= a;
                        r_b_sh    <= b;
                        r_carry   <= cin;
                        r_sum_sh  <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_sum_sh  <= w_sum_next;
                    r_carry   <= w_c;
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                    // Result registers update only here and persist until the next completion.
                    if (w_last) begin
                        r_sum       <= w_sum_next;
                        r_cout      <= w_c;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: directed vector table, hand-written corner sequences, exhaustive
// WIDTH=1 and random WIDTH=8 operations checked against plain integer addition.
module tb_serial_adder;

    logic       clock = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    logic       rst1;
    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        int         stall;
        string      name;
    } vec_t;

    vec_t vecs[4];

    serial_adder #(.WIDTH(8)) dut8 (
        .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clock(clock), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete WIDTH=8 operation: accept, latency, result, optional stall, release.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [7:0] es, input logic eco, input int stall,
                          input string nm);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        check({nm, " in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        check({nm, " busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clock);
            cnt++;
        end
        check({nm, " latency"}, 32'(cnt), 32'd8);
        check({nm, " sum"}, 32'(sum), 32'(es));
        check({nm, " cout"}, 32'(cout), 32'(eco));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check({nm, " held valid"}, 32'(out_valid), 32'd1);
            check({nm, " held result"}, 32'({cout, sum}), 32'({eco, es}));
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({nm, " valid drop"}, 32'(out_valid), 32'd0);
        check({nm, " ready back"}, 32'(in_ready), 32'd1);
    endtask

    // One WIDTH=1 operation with the consumer always ready.
    task automatic run_op1(input logic ta, input logic tb, input logic tc);
        int cnt;
        int unsigned tot;
        tot = 32'(ta) + 32'(tb) + 32'(tc);
        cnt = 0;
        while (!in_ready1 && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        a1 = ta; b1 = tb; cin1 = tc; in_valid1 = 1'b1;
        @(negedge clock);
        in_valid1 = 1'b0;
        cnt = 0;
        while (!out_valid1 && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        check("w1 latency", 32'(cnt), 32'd1);
        check("w1 result", 32'({cout1, sum1}), tot);
        @(negedge clock);
        check("w1 valid drop", 32'(out_valid1), 32'd0);
    endtask

    initial begin
        int cnt;
        int seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int unsigned tot;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "ff_01"};
        vecs[1] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 0, "0f_f0_c"};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, "12_34"};
        vecs[3] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 5, "backpressure"};

        rst = 1'b1; rst1 = 1'b1;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; out_ready1 = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst sum", 32'(sum), 32'd0);
            check("rst cout", 32'(cout), 32'd0);
            check("rst out_valid", 32'(out_valid), 32'd0);
            check("rst busy", 32'(busy), 32'd0);
            check("rst in_ready", 32'(in_ready), 32'd0);
        end
        rst = 1'b0; rst1 = 1'b0;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        check("release in_ready w1", 32'(in_ready1), 32'd1);
        @(negedge clock);

        for (int i = 0; i < 4; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum,
                   vecs[i].exp_cout, vecs[i].stall, vecs[i].name);

        // in_valid pulses during BUSY and DONE must not disturb the running addition.
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        a = 8'h77; b = 8'h77; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clock);
            cnt++;
        end
        check("ignore busy sum", 32'({cout, sum}), 32'h046);
        a = 8'h77; b = 8'h77; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        check("ignore done valid", 32'(out_valid), 32'd1);
        check("ignore done sum", 32'({cout, sum}), 32'h046);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("ignore valid drop", 32'(out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (out_valid || busy) seen++;
        end
        check("ignore no second op", 32'(seen), 32'd0);

        // Reset lands on the 4th BUSY cycle of FF+FF.
        a = 8'hFF; b = 8'hFF; cin = 1'b0; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        check("midrst sum", 32'(sum), 32'd0);
        check("midrst cout", 32'(cout), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("midrst no result", 32'(seen), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, "after_rst");

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_op1(v[2], v[1], v[0]);
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            tot = 32'(ra) + 32'(rb) + 32'(rc);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            run_op(ra, rb, rc, tot[7:0], tot[8], int'($urandom_range(0, 3)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
